// File: rtl/dct_transpose_buffer.sv
// rtl/dct_transpose_buffer.sv - ping-pong NxN transpose memory between row and column DCT stages
// Rows are written into one bank while the other bank is read out column by column.
module dct_transpose_buffer #(
  parameter int DATA_W = 11,
  parameter int N      = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic                out_first,
  output logic                out_last
);

  localparam int              CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  logic                wb_q, wb_d;
  logic                rb_q, rb_d;
  logic [CNT_W-1:0]    wr_row_q, wr_row_d;
  logic [CNT_W-1:0]    rd_col_q, rd_col_d;
  logic [1:0]          full_q, full_d;

  logic [N*DATA_W-1:0] bank0_q [N];
  logic [N*DATA_W-1:0] bank1_q [N];

  logic                wr_acc, wr_done;
  logic                rd_acc, rd_done;

  assign in_ready  = ~full_q[wb_q];
  assign out_valid = full_q[rb_q];
  assign out_first = out_valid & (rd_col_q == '0);
  assign out_last  = out_valid & (rd_col_q == LAST_IDX);

  assign wr_acc  = in_valid & in_ready;
  assign wr_done = wr_acc & (wr_row_q == LAST_IDX);
  assign rd_acc  = out_valid & out_ready;
  assign rd_done = rd_acc & (rd_col_q == LAST_IDX);

  // The full flags keep reader and writer on different banks, so a set on
  // one bank and a clear on the other can land in the same cycle.
  always_comb begin
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_row_d = wr_row_q;
    rd_col_d = rd_col_q;
    full_d   = full_q;
    if (wr_acc) begin
      wr_row_d = wr_done ? '0 : wr_row_q + 1'b1;
    end
    if (wr_done) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
    end
    if (rd_acc) begin
      rd_col_d = rd_done ? '0 : rd_col_q + 1'b1;
    end
    if (rd_done) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_row_q <= '0;
      rd_col_q <= '0;
      full_q   <= '0;
    end else begin
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_row_q <= wr_row_d;
      rd_col_q <= rd_col_d;
      full_q   <= full_d;
    end
  end

  // Bank storage carries no reset; validity is tracked solely by full_q.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (wb_q) begin
        bank1_q[wr_row_q] <= in_data;
      end else begin
        bank0_q[wr_row_q] <= in_data;
      end
    end
  end

  always_comb begin
    logic [N*DATA_W-1:0] row_word;
    row_word = '0;
    out_data = '0;
    for (int r = 0; r < N; r++) begin
      row_word = rb_q ? bank1_q[r] : bank0_q[r];
      for (int c = 0; c < N; c++) begin
        if (out_valid && (rd_col_q == CNT_W'(c))) begin
          out_data[r*DATA_W +: DATA_W] = row_word[c*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// tb/tb_dct_transpose_buffer.sv - scoreboard bench for dct_transpose_buffer
module tb_dct_transpose_buffer;

  localparam int W  = 11;
  localparam int N  = 16;
  localparam int BW = N * W;

  typedef struct {
    logic [BW-1:0] data;
    logic          first;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_first;
  logic          out_last;

  beat_t         exp_q[$];
  beat_t         mon_b;
  logic [BW-1:0] blk_rows [N];
  int            row_cnt = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            beats = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  bit            rnd_done;

  dct_transpose_buffer #(.DATA_W(W), .N(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: collect N rows, then the expected output is the matrix transpose.
  task automatic model_accept(input logic [BW-1:0] d);
    beat_t b;
    blk_rows[row_cnt] = d;
    row_cnt++;
    if (row_cnt == N) begin
      for (int c = 0; c < N; c++) begin
        b.data = '0;
        for (int r = 0; r < N; r++) b.data[r*W +: W] = blk_rows[r][c*W +: W];
        b.first = (c == 0);
        b.last  = (c == N - 1);
        exp_q.push_back(b);
      end
      row_cnt = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got %h expected no beat", out_data);
          end else begin
            mon_b = exp_q.pop_front();
            chk("beat_data", out_data, mon_b.data);
            chk("beat_first", BW'(out_first), BW'(mon_b.first));
            chk("beat_last", BW'(out_last), BW'(mon_b.last));
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
          end
        end
      end else begin
        chk("idle_data", out_data, '0);
        chk("idle_flags", BW'({out_first, out_last}), '0);
      end
    end
  end

  function automatic logic [BW-1:0] seq_row(input int base, input int r);
    logic [BW-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = W'(base + r * N + c);
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_row();
    logic [BW-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = W'($urandom);
    return v;
  endfunction

  function automatic logic [BW-1:0] sign_row();
    logic [BW-1:0] v;
    logic [W-1:0]  pats [4];
    pats[0] = 11'h7FF;
    pats[1] = 11'h400;
    pats[2] = 11'h3FF;
    pats[3] = 11'h001;
    for (int c = 0; c < N; c++) v[c*W +: W] = pats[$urandom_range(0, 3)];
    return v;
  endfunction

  task automatic send_row(input logic [BW-1:0] d, output int waits);
    bit acc;
    acc      = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (acc) begin
      model_accept(d);
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", BW'(exp_q.size()), '0);
  endtask

  task automatic single_block(input int base);
    int w;
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      send_row(seq_row(base, r), w);
      chk("single_no_stall", BW'(w), '0);
      if (r == N - 2) chk("lat_before_last_row", BW'(out_valid), BW'(1'b0));
      if (r == N - 1) begin
        chk("lat_col0_valid", BW'(out_valid), BW'(1'b1));
        chk("lat_col0_first", BW'(out_first), BW'(1'b1));
      end
    end
    drain();
    chk("single_after_valid", BW'(out_valid), '0);
    chk("single_after_data", out_data, '0);
  endtask

  initial begin
    int w, wsum;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", BW'(in_ready), BW'(1'b1));
    chk("rst_out_valid", BW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_flags", BW'({out_first, out_last}), '0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    single_block(0);

    beats = 0;
    wsum  = 0;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < N; r++) begin
        send_row(seq_row(b * 256, r), w);
        wsum += w;
      end
    end
    drain();
    chk("b2b_in_ready_stalls", BW'(wsum), '0);
    chk("b2b_beats", BW'(beats), BW'(3 * N));
    chk("b2b_no_bubble", BW'(last_cyc - first_cyc), BW'(3 * N - 1));

    out_ready = 1'b0;
    for (int r = 0; r < 2 * N; r++) send_row(rand_row(), w);
    in_valid = 1'b1;
    in_data  = rand_row();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_held_in_ready", BW'(in_ready), '0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("bp_drain_in_ready", BW'(in_ready), '0);
      @(posedge clk);
      #1;
    end
    chk("bp_in_ready_rise", BW'(in_ready), BW'(1'b1));
    @(negedge clk);
    @(posedge clk);
    #1;
    model_accept(in_data);
    in_valid = 1'b0;
    for (int r = 1; r < N; r++) send_row(rand_row(), w);
    drain();

    out_ready = 1'b1;
    for (int r = 0; r < N; r++) send_row(sign_row(), w);
    drain();

    out_ready = 1'b0;
    for (int r = 0; r < N; r++) send_row(rand_row(), w);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", out_data, exp_q[0].data);
      chk("stall_valid", BW'(out_valid), BW'(1'b1));
      chk("stall_flags", BW'({out_first, out_last}), '0);
    end
    drain();

    out_ready = 1'b0;
    for (int r = 0; r < N + 7; r++) send_row(rand_row(), w);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_in_ready", BW'(in_ready), BW'(1'b1));
    chk("arst_out_valid", BW'(out_valid), '0);
    chk("arst_out_data", out_data, '0);
    chk("arst_flags", BW'({out_first, out_last}), '0);
    exp_q.delete();
    row_cnt = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    single_block(4);

    rnd_done = 1'b0;
    fork
      begin
        for (int r = 0; r < 4 * N; r++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_row(rand_row(), w);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dct_transpose_buffer.md
Name: dct_transpose_buffer

Overview:
- Ping-pong 16x16 transpose memory between the row (1-D) DCT stage and the column DCT stage (DCT_col) of the 2-D DCT datapath.
- Accepts one row of N coefficients per cycle from the row stage.
- After a full N-row block is stored, it emits that block one column per cycle to the column stage.
- Two banks allow one block to be written while the previous block is read, giving full throughput.

Parameters:
- DATA_W, 11, width of each coefficient word (two's complement).
- N, 16, block dimension: lanes per beat, rows and columns per block.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  in_data carries a valid row
- in_ready  output  1  buffer can accept a row this cycle
- in_data  input  N*DATA_W  row r, lane c at bits [c*DATA_W +: DATA_W] = element (r,c)
- out_valid  output  1  out_data carries a valid column
- out_ready  input  1  column stage consumes the column this cycle
- out_data  output  N*DATA_W  column c, lane r at bits [r*DATA_W +: DATA_W] = element (r,c)
- out_first  output  1  high with column 0 of a block
- out_last  output  1  high with column N-1 of a block

Behaviour:
- Storage: two banks (0,1), each N x N words of DATA_W. Bank contents are not reset.
- Write side: pointer wb (1 bit), row counter wr_row (0..N-1), per-bank full flag.
  - in_ready = ~full[wb].
  - Row accept = in_valid & in_ready. On accept, row stored at bank wb, row wr_row; wr_row increments.
  - On accept with wr_row==N-1: full[wb] set, wb toggles, wr_row wraps to 0.
  - in_valid while in_ready=0: row not stored, no state change. Upstream holds the row.
- Read side: pointer rb (1 bit), column counter rd_col (0..N-1).
  - out_valid = full[rb].
  - out_data is a combinational select of column rd_col from bank rb, and is forced to 0 when out_valid=0.
  - out_first = out_valid & (rd_col==0); out_last = out_valid & (rd_col==N-1).
  - Column consume = out_valid & out_ready. On consume, rd_col increments.
  - On consume with rd_col==N-1: full[rb] cleared, rb toggles, rd_col wraps to 0.
  - out_data stays stable while out_valid & ~out_ready.
- Latency: the column-0 beat asserts out_valid in the cycle after the N-th row of a block is accepted. No output beats for a block occur before all N of its rows are accepted.
- Throughput: with out_ready held at 1, back-to-back input blocks give back-to-back output blocks, and in_ready never deasserts.
- Simultaneous events:
  - Setting full[x] and clearing full[y] in the same cycle (x≠y) are both applied.
  - A bank cleared in cycle t presents in_ready=1 to the write side from cycle t+1. There is no same-cycle write-through.
  - Read and write never target the same bank at once. Guaranteed by the full flags.
- Full/empty:
  - Both banks full: in_ready=0.
  - Both banks empty: out_valid=0, out_data=0, out_first=0, out_last=0.
- Width rule: words pass through bit-exact; no rounding, truncation or sign extension.
- Reset (asynchronous, any time, including mid-block or mid-read):
  - wb=rb=0, wr_row=rd_col=0, full[1:0]=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_first=0, out_last=0.
  - A partially written or partially read block is discarded.
  - After rstn rises, the first accepted row is row 0 of a new block in bank 0.

Test Plan:
- Single block, element (r,c)=r*16+c, out_ready=1 -> out_valid first high in the cycle after the 16th accept. Column c lane r = r*16+c, e.g. column 3 lanes = 3,19,35,...,243. out_first only with column 0, out_last only with column 15. out_valid then low, out_data=0.
- Three blocks back-to-back (48 consecutive in_valid rows, block b values offset by b*256), out_ready=1 -> in_ready never low. 48 consecutive output beats with no bubble; each block transposed correctly.
- Backpressure: out_ready=0, in_valid continuous -> 32 rows accepted, then in_ready=0 and row 33 held. Raising out_ready for 16 beats drains block 0. in_ready rises the cycle after the last column is consumed, and row 33 is accepted then.
- Sign/width: lanes 0x7FF (-1), 0x400 (-1024), 0x3FF (+1023) -> same bit patterns appear at the transposed positions unchanged.
- Reset mid-operation: assert rstn=0 after 7 rows of block 1 while block 0 is at column 5 -> outputs go to reset values asynchronously. A fresh block then behaves exactly as in the first scenario.
- Stall stability: hold out_ready=0 for 5 cycles at column 8 -> out_data, out_valid and rd_col unchanged. out_first=out_last=0 throughout.
